// File: rtl/adder_seq_pkg.sv
// Shared definitions for the sequential multi-word adder/subtractor.
package adder_seq_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Beat counter width: enough to count WORDS beats, never narrower than one bit.
    function automatic int cnt_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/ripple_carry_adder8.sv
// 8-bit ripple-carry adder; one full-adder cell per bit, carry chained LSB to MSB.
module ripple_carry_adder8
    import adder_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    // Ripple the carry through the slice bit by bit
    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential wide add/subtract: one 8-bit slice per cycle through a single
// ripple-carry adder, carry registered between beats, valid/ready on both sides.
module multiword_add_seq
    import adder_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SLICE_W*WORDS-1:0]   op_a,
    input  logic [SLICE_W*WORDS-1:0]   op_b,
    input  logic                       op_cin,
    input  logic                       op_sub,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SLICE_W*WORDS-1:0]   result,
    output logic                       cout,
    output logic                       ovf
);

    localparam int W     = SLICE_W * WORDS;
    localparam int CNT_W = cnt_width(WORDS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS - 1);

    seq_state_t state_q, state_d;

    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             sub_q, sub_d;
    logic [W-1:0]     res_q, res_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
    logic               slice_cout;
    logic               last_beat;

    // Operands are consumed from the bottom and shifted down one slice per
    // beat; results enter at the top, so after WORDS beats slice k sits at
    // bits [8k+7:8k].
    logic [W+SLICE_W-1:0] a_ext, b_ext, res_ext;

    assign slice_a   = a_q[SLICE_W-1:0];
    assign slice_b   = b_q[SLICE_W-1:0] ^ {SLICE_W{sub_q}};
    assign last_beat = (cnt_q == LAST_BEAT);
    assign a_ext     = {{SLICE_W{1'b0}}, a_q};
    assign b_ext     = {{SLICE_W{1'b0}}, b_q};
    assign res_ext   = {slice_sum, res_q};

    ripple_carry_adder8 u_adder (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_beat) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake flags are pure functions of state
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath next values: capture on accept, one slice per RUN beat
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        res_d   = res_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    sub_d   = op_sub;
                    cnt_d   = '0;
                    // Subtraction is A + ~B + 1 - borrow, so borrow-in inverts.
                    carry_d = op_sub ? ~op_cin : op_cin;
                end
            end
            RUN: begin
                a_d     = a_ext[W+SLICE_W-1:SLICE_W];
                b_d     = b_ext[W+SLICE_W-1:SLICE_W];
                res_d   = res_ext[W+SLICE_W-1:SLICE_W];
                carry_d = slice_cout;
                if (last_beat) begin
                    // Carry into bit 7 xor carry out of bit 7 of the top slice.
                    ovf_d = slice_a[SLICE_W-1] ^ slice_b[SLICE_W-1]
                          ^ slice_sum[SLICE_W-1] ^ slice_cout;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // After the last beat the carry register holds the MSB slice carry-out
    // and stays put until the next request is accepted.
    assign result = res_q;
    assign cout   = carry_q;
    assign ovf    = ovf_q;

endmodule

// File: doc/multiword_add_seq.md
# multiword_add_seq

Sequential wide-operand adder/subtractor that sits directly upstream of, and drives, the 8-bit ripple-carry adder. It accepts two `8*WORDS`-bit operands over a valid/ready handshake. It feeds one byte slice per cycle into a single `ripple_carry_adder8` instance, registering the carry between beats. It returns the full result with carry-out and signed overflow over a second valid/ready handshake.

## Interface
- `WORDS`, default 4: number of 8-bit slices; operand width is `8*WORDS`; legal range 1..16.

Ports:
- `clk`  in  1  single clock for all state.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  operand request valid.
- `in_ready`  out  1  block can accept a request; high only in IDLE.
- `op_a`  in  8*WORDS  operand A.
- `op_b`  in  8*WORDS  operand B.
- `op_cin`  in  1  carry-in; acts as borrow-in when subtracting.
- `op_sub`  in  1  0 = A+B+cin; 1 = A−B−cin.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  8*WORDS  sum or difference.
- `cout`  out  1  raw carry out of the MSB slice; when subtracting, borrow = ~cout.
- `ovf`  out  1  two's-complement overflow of the full-width operation.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: capture `op_a`, `op_b`, and `op_sub` into registers, clear the beat counter, set the carry register to `op_sub ? ~op_cin : op_cin`, go to RUN.
- **RUN**, at beat k (0..WORDS−1):
  - Adder inputs: A=`a_q[8k+7:8k]`, B=`b_q[8k+7:8k] ^ {8{sub_q}}`, cin=carry register.
  - Write the sum into `res_q[8k+7:8k]` and load the adder's cout into the carry register.
  - On the last beat (k=WORDS−1), also latch `ovf = A[7] ^ B'[7] ^ sum[7] ^ cout`, where B' is the inverted-if-sub byte and the first three terms give the carry into bit 7. Go to DONE.
- **DONE**
  - `out_valid`=1; `result`, `cout`, and `ovf` are held stable.
  - On `out_ready`, go to IDLE.
  - A new request is not accepted in the same cycle; `in_ready` stays 0 in DONE.
- `in_valid` is ignored outside IDLE. Operands need only be stable in the accepting cycle.
- Reset, including mid-RUN or mid-DONE, forces:
  - state=IDLE, `in_ready`=1, `out_valid`=0;
  - `result`=0, `cout`=0, `ovf`=0;
  - carry register and beat counter = 0.
  - Any in-flight operation is discarded.

## Timing
- The request handshake completes at edge E0 (`in_valid & in_ready`).
- RUN occupies the WORDS cycles after E0. Slice k is registered at edge E0+k+1.
- `out_valid` rises in the cycle after edge E0+WORDS: latency is WORDS+1 cycles from acceptance to `out_valid`.
- Minimum request-to-request spacing is WORDS+2 cycles, with `out_ready` held high.
- `out_valid` stays high indefinitely under backpressure. Outputs must not change while `out_valid & ~out_ready`.
- `result` is registered only. The combinational path per cycle is exactly one 8-bit ripple chain plus the B-inversion XOR.
- Beat counter width is `$clog2(WORDS)` with a minimum of 1. It must not wrap before the DONE transition; WORDS=1 goes IDLE→RUN(1 beat)→DONE.

## Structure
- Shared package `adder_seq_pkg`:
  - `SLICE_W = 8`;
  - state enum `seq_state_t {IDLE, RUN, DONE}`.
- One sub-module: `ripple_carry_adder8`, instantiated exactly once and reused every beat (ports a, b, cin, sum, cout).
- Top level holds the FSM, operand/result registers, carry register, and beat counter.

## Test plan
(WORDS=4 unless stated.)
- Add, carry ripples across every slice: A=0xFFFFFFFF, B=0x00000001, cin=0, sub=0 → `result`=0x00000000, `cout`=1, `ovf`=0; `out_valid` exactly 5 cycles after acceptance.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001, add → `result`=0x80000000, `cout`=0, `ovf`=1.
- Subtract with borrow: A=0x00000005, B=0x00000007, cin=0, sub=1 → `result`=0xFFFFFFFE, `cout`=0 (borrow), `ovf`=0. Then A=0x80000000, B=1, sub=1 → `result`=0x7FFFFFFF, `ovf`=1.
- Backpressure: hold `out_ready`=0 for 6 cycles after `out_valid`; pulse `in_valid` with new operands during that time.
  - Expect: outputs stable and `in_ready`=0 throughout; the new request is ignored.
  - After `out_ready`, `in_ready`=1 the next cycle.
- Reset mid-RUN: assert `rst` during beat 2 → all outputs 0 immediately (async), `in_ready`=1; the next request completes with a correct result.
- WORDS=1 build: A=0xFF, B=0x01, cin=1 → `result`=0x01, `cout`=1, `ovf`=0; latency 2 cycles.
